// File: rtl/cfg_spi_sequencer.sv
// cfg_spi_sequencer: streams NUM_ENTRIES table words out over mode-0 SPI; CFG_AUTOSTART_EN adds a one-shot power-up start.
// Latency: cs_n falls two edges after start is sampled; no backpressure, start is dropped while a sequence runs.
module cfg_spi_sequencer #(
    parameter int NUM_ENTRIES      = 20,
    parameter int CLK_DIV          = 4,
    parameter int GAP_CYCLES       = 8,
    parameter int AUTOSTART_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        busy,
    output logic        done,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi
);

    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [4:0]       ADDR_LAST = 5'(NUM_ENTRIES - 1);

    if (NUM_ENTRIES < 1 || NUM_ENTRIES > 32 || CLK_DIV < 1 || GAP_CYCLES < 1 || AUTOSTART_CYCLES < 1) begin : g_param_check
        $error("cfg_spi_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        addr_nxt;
    logic              busy_nxt, done_nxt;
    logic              cs_n_nxt, sclk_nxt, mosi_nxt;
    // Only the 15 bits still to be sent are kept; bit 15 goes straight to mosi on fetch.
    logic [14:0]       shift_reg, shift_nxt;
    logic [3:0]        bit_cnt, bit_nxt;
    logic [PH_W-1:0]   phase_cnt, phase_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic              start_go;

`ifdef CFG_AUTOSTART_EN
    localparam int AUTO_W = $clog2(AUTOSTART_CYCLES + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTOSTART_CYCLES);

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_armed;
    logic              auto_fire;

    assign auto_fire = auto_armed && (state == S_IDLE) && (auto_cnt == AUTO_LAST);
    assign start_go  = start | auto_fire;

    // Armed once per reset; any accepted start (external or internal) disarms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt   <= '0;
            auto_armed <= 1'b1;
        end else if (auto_armed && (state == S_IDLE)) begin
            if (start || auto_fire) begin
                auto_armed <= 1'b0;
            end else begin
                auto_cnt <= auto_cnt + 1'b1;
            end
        end
    end
`else
    assign start_go = start;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            spi_cs_n  <= cs_n_nxt;
            spi_sclk  <= sclk_nxt;
            spi_mosi  <= mosi_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_nxt;
            phase_cnt <= phase_nxt;
            gap_cnt   <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        busy_nxt  = busy;
        done_nxt  = done;
        cs_n_nxt  = spi_cs_n;
        sclk_nxt  = spi_sclk;
        mosi_nxt  = spi_mosi;
        shift_nxt = shift_reg;
        bit_nxt   = bit_cnt;
        phase_nxt = phase_cnt;
        gap_nxt   = gap_cnt;

        case (state)
            S_IDLE, S_DONE: begin
                if (start_go) begin
                    state_nxt = S_FETCH;
                    addr_nxt  = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                end
            end

            S_FETCH: begin
                shift_nxt = rom_data[14:0];
                mosi_nxt  = rom_data[15];
                cs_n_nxt  = 1'b0;
                sclk_nxt  = 1'b0;
                bit_nxt   = '0;
                phase_nxt = '0;
                state_nxt = S_SHIFT;
            end

            S_SHIFT: begin
                if (phase_cnt != PH_LAST) begin
                    phase_nxt = phase_cnt + 1'b1;
                end else begin
                    phase_nxt = '0;
                    if (!spi_sclk) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        // Falling edge: advance data, or close the frame after bit 0.
                        sclk_nxt = 1'b0;
                        if (bit_cnt != 4'd15) begin
                            mosi_nxt  = shift_reg[14];
                            shift_nxt = {shift_reg[13:0], 1'b0};
                            bit_nxt   = bit_cnt + 1'b1;
                        end else begin
                            cs_n_nxt  = 1'b1;
                            mosi_nxt  = 1'b0;
                            gap_nxt   = '0;
                            state_nxt = S_GAP;
                        end
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt != GAP_LAST) begin
                    gap_nxt = gap_cnt + 1'b1;
                end else if (rom_addr == ADDR_LAST) begin
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    addr_nxt  = rom_addr + 1'b1;
                    state_nxt = S_FETCH;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cfg_spi_sequencer.sv
// Bench for cfg_spi_sequencer: cycle-position model of the SPI waveform plus directed scenarios with literal expectations.
module tb_cfg_spi_sequencer;

    localparam int NE  = 20;
    localparam int CD  = 4;
    localparam int GP  = 8;
    localparam int W1  = 1 + 32 * CD + GP;
    localparam int NE2 = 1;
    localparam int CD2 = 1;
    localparam int GP2 = 1;
    localparam int W2  = 1 + 32 * CD2 + GP2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [4:0]  rom_addr, rom_addr2;
    logic [15:0] rom_data, rom_data2;
    logic        busy, done, spi_cs_n, spi_sclk, spi_mosi;
    logic        busy2, done2, spi_cs_n2, spi_sclk2, spi_mosi2;

    logic [15:0] words [20] = '{16'h0A01, 16'h1B5A, 16'h2CA5, 16'h3D00, 16'h4EFF,
                                16'h5F81, 16'h6012, 16'h7134, 16'h8256, 16'h9378,
                                16'hA49A, 16'hB5BC, 16'hC6DE, 16'hD7F0, 16'hE80F,
                                16'hF9C3, 16'h0A3C, 16'h1B99, 16'h2C66, 16'h3DE7};
    logic [15:0] tbl  [32];
    logic [15:0] tbl2 [32];

    always #5 clk = ~clk;

    assign rom_data  = tbl[rom_addr];
    assign rom_data2 = tbl2[rom_addr2];

    cfg_spi_sequencer #(.NUM_ENTRIES(NE), .CLK_DIV(CD), .GAP_CYCLES(GP), .AUTOSTART_CYCLES(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .done(done), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi)
    );

    cfg_spi_sequencer #(.NUM_ENTRIES(NE2), .CLK_DIV(CD2), .GAP_CYCLES(GP2), .AUTOSTART_CYCLES(16)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .busy(busy2), .done(done2), .spi_cs_n(spi_cs_n2), .spi_sclk(spi_sclk2), .spi_mosi(spi_mosi2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: a run is described only by the edge at which start was accepted;
    // outputs follow from the position k (edges since then) inside fixed-length word slots.
    int edge_n = 0;
    bit run1 = 1'b0, run2 = 1'b0;
    int t1 = 0, t2 = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) run1 <= 1'b0;
        else if (start && (!run1 || (edge_n - 1 - t1) >= NE * W1)) begin
            run1 <= 1'b1;
            t1   <= edge_n;
        end
        if (rst) run2 <= 1'b0;
        else if (start2 && (!run2 || (edge_n - 1 - t2) >= NE2 * W2)) begin
            run2 <= 1'b1;
            t2   <= edge_n;
        end
    end

    function automatic logic [9:0] model_out(input bit run, input int k, input int cd, input int gp,
                                             input int ne, input logic [15:0] t [32]);
        int wlen, w, r, s, bitn;
        logic [4:0] a;
        logic b, d, cs, sc, mo;
        wlen = 1 + 32 * cd + gp;
        a = '0; b = 1'b0; d = 1'b0; cs = 1'b1; sc = 1'b0; mo = 1'b0;
        if (run) begin
            if (k >= ne * wlen) begin
                a = 5'(ne - 1);
                d = 1'b1;
            end else begin
                w = k / wlen;
                r = k % wlen;
                a = 5'(w);
                b = 1'b1;
                if (r >= 1 && r <= 32 * cd) begin
                    s    = r - 1;
                    bitn = s / (2 * cd);
                    cs   = 1'b0;
                    sc   = ((s / cd) % 2) == 1;
                    mo   = t[w][15 - bitn];
                end
            end
        end
        return {a, b, d, cs, sc, mo};
    endfunction

    logic [9:0] exp1, act1, exp2, act2;
    always @(negedge clk) begin
        if (chk_en) begin
            exp1 = model_out(run1, edge_n - 1 - t1, CD, GP, NE, tbl);
            act1 = {rom_addr, busy, done, spi_cs_n, spi_sclk, spi_mosi};
            n_chk++;
            if (act1 === exp1) n_pass++;
            else $display("FAIL model_dut edge %0d: got addr/busy/done/cs_n/sclk/mosi=%b, expected %b", edge_n - 1, act1, exp1);
            exp2 = model_out(run2, edge_n - 1 - t2, CD2, GP2, NE2, tbl2);
            act2 = {rom_addr2, busy2, done2, spi_cs_n2, spi_sclk2, spi_mosi2};
            n_chk++;
            if (act2 === exp2) n_pass++;
            else $display("FAIL model_dut2 edge %0d: got addr/busy/done/cs_n/sclk/mosi=%b, expected %b", edge_n - 1, act2, exp2);
        end
    end

    // SPI decoder for the default-parameter instance.
    logic [15:0] cur = '0;
    int rises = 0, low_cnt = 0, high_cnt = 0;
    logic p_sclk = 1'b0, p_cs = 1'b1;
    logic [15:0] wq [$];
    int lq [$], rq [$], gq [$];

    always @(negedge clk) begin
        if (chk_en) begin
            if (spi_cs_n === 1'b0) begin
                if (p_cs) begin
                    gq.push_back(high_cnt);
                    high_cnt = 0; cur = '0; rises = 0; low_cnt = 0;
                end
                low_cnt++;
                if (spi_sclk && !p_sclk) begin
                    cur = {cur[14:0], spi_mosi};
                    rises++;
                end
            end else begin
                if (p_cs === 1'b0) begin
                    wq.push_back(cur); lq.push_back(low_cnt); rq.push_back(rises);
                end
                high_cnt++;
            end
            p_sclk = spi_sclk;
            p_cs   = spi_cs_n;
        end
    end

    task automatic clear_mon();
        wq.delete(); lq.delete(); rq.delete(); gq.delete();
    endtask

    int s1, s2, dt, fall, lowc;
    bit got;

    initial begin
        for (int i = 0; i < 32; i++) begin
            tbl[i]  = (i < 20) ? words[i] : 16'h0000;
            tbl2[i] = 16'h0000;
        end
        tbl2[0] = 16'hC35A;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_cs_n", spi_cs_n, 1);
        check("reset_rom_addr", rom_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // Minimal configuration: one word, CLK_DIV=1, GAP_CYCLES=1.
        start2 = 1'b1; s2 = edge_n; lowc = 0; got = 1'b0; dt = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            start2 = 1'b0;
            if (spi_cs_n2 == 1'b0) lowc++;
            if (done2) begin got = 1'b1; dt = edge_n - s2; end
        end
        check("small_done_seen", got, 1);
        check("small_done_cycles", dt, 35);
        check("small_cs_low_cycles", lowc, 32);

        // Full sequence with stray start pulses during SHIFT and GAP.
        clear_mon();
        start = 1'b1; s1 = edge_n; fall = 0; got = 1'b0; dt = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #1;
            start = (i == 60 || i == 130 || i == 131 || i == 700 || i == 1500) ? 1'b1 : 1'b0;
            if (spi_cs_n == 1'b0 && fall == 0) fall = edge_n - s1;
            if (done) begin got = 1'b1; dt = edge_n - s1; end
        end
        start = 1'b0;
        check("full_done_seen", got, 1);
        check("cs_fall_edges", fall, 2);
        check("full_done_cycles", dt, 2741);
        check("word_count", wq.size(), 20);
        check("word0_literal", (wq.size() > 0) ? wq[0] : 16'hFFFF, 16'h0A01);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("word%0d", i), (i < wq.size()) ? wq[i] : 16'hDEAD, words[i]);
            check($sformatf("cs_low%0d", i), (i < lq.size()) ? lq[i] : -1, 128);
            check($sformatf("sclk_rises%0d", i), (i < rq.size()) ? rq[i] : -1, 16);
            if (i > 0) check($sformatf("gap%0d", i), (i < gq.size()) ? gq[i] : -1, 9);
        end

        // Restart from DONE.
        repeat (3) @(negedge clk);
        #1;
        check("done_hold", done, 1);
        check("done_addr", rom_addr, 19);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check("restart_done_clear", done, 0);
        check("restart_busy", busy, 1);
        check("restart_addr", rom_addr, 0);

        // Reset in the middle of word 5, bit 7.
        got = 1'b0;
        for (int i = 0; i < 1500 && !got; i++) begin
            @(negedge clk); #1;
            if (rom_addr == 5'd5 && spi_cs_n == 1'b0 && rises == 8) got = 1'b1;
        end
        check("midword_reached", got, 1);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("midrst_cs_n", spi_cs_n, 1);
        check("midrst_sclk", spi_sclk, 0);
        check("midrst_mosi", spi_mosi, 0);
        check("midrst_addr", rom_addr, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1;
        clear_mon();
        start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (wq.size() > 0) got = 1'b1;
        end
        check("post_rst_word_seen", got, 1);
        check("post_rst_word0", (wq.size() > 0) ? wq[0] : 16'hFFFF, 16'h0A01);
        check("post_rst_rises", (rq.size() > 0) ? rq[0] : -1, 16);

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cfg_spi_sequencer.md
# cfg_spi_sequencer

Sequences the 20-entry register-configuration table (5-bit index → 16-bit {reg_addr[15:8], reg_data[7:0]} word) out to the external converter over a 4-wire SPI write-only link. Drives the table index, latches each word, serializes it MSB-first, and enforces a chip-select gap between words. Sits between the configuration-table lookup and the device pins, and is started once after power-up or on demand by the control logic.

## Interface
- NUM_ENTRIES, 20, number of table words sent per sequence (1..32)
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)
- GAP_CYCLES, 8, clk cycles cs_n held high between words (≥1)
- AUTOSTART_CYCLES, 1024, power-up wait before automatic start (used only with CFG_AUTOSTART_EN)
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a full sequence; sampled only in IDLE
- rom_addr  output  5  table index currently addressed
- rom_data  input  16  table word for rom_addr (combinational table, valid same cycle)
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  high in DONE; cleared when a new start is accepted or by rst
- spi_cs_n  output  1  chip select, active low
- spi_sclk  output  1  serial clock, idle low (mode 0)
- spi_mosi  output  1  serial data, MSB first

## Operation
- Reset values: rom_addr=0, busy=0, done=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, state=IDLE.
- States: IDLE, FETCH, SHIFT, GAP, DONE.
- IDLE: start=1 → FETCH, rom_addr←0, busy←1, done←0.
- FETCH (1 cycle): shift_reg←rom_data, spi_cs_n←0, spi_mosi←rom_data[15], bit counter←0 → SHIFT.
- SHIFT: phase counter runs 0..CLK_DIV-1 per half-period. Low half: spi_sclk=0; end of low half → spi_sclk←1. End of high half → spi_sclk←0; if bit counter<15, shift left, spi_mosi←next bit, bit counter+1; if bit counter=15, spi_cs_n←1, spi_mosi←0 → GAP.
- GAP: count GAP_CYCLES cycles. At end: if rom_addr=NUM_ENTRIES-1 → DONE; else rom_addr+1 → FETCH.
- DONE: busy=0, done=1, rom_addr holds last index; start=1 → behaves as IDLE start (restarts from index 0).
- start while busy (FETCH/SHIFT/GAP) ignored, not queued.
- rst at any point (including mid-word): next edge returns all outputs to reset values; partial word abandoned, cs_n deasserted immediately; no resume.
- Counters sized to their maximum (phase: clog2(CLK_DIV), gap: clog2(GAP_CYCLES+1), bit: 4 bits); rom_addr never exceeds NUM_ENTRIES-1.

## Timing
- start high in IDLE at edge N → busy=1 and FETCH after N; cs_n falls and first MOSI bit valid after edge N+1.
- cs_n low per word: exactly 32·CLK_DIV cycles; 16 SCLK rising edges, first at 1·CLK_DIV cycles after cs_n falls.
- MOSI changes only on SCLK falling edge (or cs_n fall); stable for CLK_DIV cycles either side of every SCLK rise.
- cs_n high between words: GAP_CYCLES + 1 cycles (GAP + FETCH).
- Full sequence, start accepted → done=1: NUM_ENTRIES·(1 + 32·CLK_DIV + GAP_CYCLES) + 1 cycles (defaults: 20·137+1 = 2741).

## Configuration
- CFG_AUTOSTART_EN defined: after rst deasserts, an internal counter waits AUTOSTART_CYCLES cycles in IDLE, then starts the sequence exactly as if start were pulsed; fires once per reset; an external start during the wait starts immediately and cancels the autostart.
- Not defined: no wait counter; sequence starts only on start input.

## Test plan
- Defaults, table word 0 = 16'h0A01: pulse start → cs_n falls 2 edges later; decoded SPI word 0 = 0x0A01, 16 SCLK rises, cs_n low exactly 128 cycles.
- Full run: 20 distinct table words → SPI monitor captures all 20 in index order, cs_n high 9 cycles between words, done=1 exactly 2741 cycles after start accepted.
- start pulsed repeatedly during SHIFT and GAP → no effect; sequence count and timing unchanged; start in DONE → restarts from index 0, done clears.
- rst asserted mid-word 5, bit 7 → next edge cs_n=1, sclk=0, mosi=0, rom_addr=0, busy=0; following start sends word 0 first.
- CLK_DIV=1, GAP_CYCLES=1, NUM_ENTRIES=1 → single 32-cycle cs_n window, done after 35 cycles.
- CFG_AUTOSTART_EN, AUTOSTART_CYCLES=16: release rst, no start → busy rises 17 cycles later (counter + start edge); never fires a second time without rst.
